// File: rtl/spi_byte_engine_if.sv
// spi_byte_engine_if
//   Byte-level handshake between the SPI peripheral front end and the
//   spi_byte_engine.
//   tx_byte  : byte to send, sampled on an accepted tx_dv
//   tx_dv    : transmit request
//   tx_ready : engine idle / can accept (combinational from the engine)
//   rx_dv    : one-cycle pulse, rx_byte valid
//   rx_byte  : last received byte
//   master modport = upstream peripheral, slave modport = engine.
interface spi_byte_engine_if;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (
    output tx_byte,
    output tx_dv,
    input  tx_ready,
    input  rx_dv,
    input  rx_byte
  );

  modport slave (
    input  tx_byte,
    input  tx_dv,
    output tx_ready,
    output rx_dv,
    output rx_byte
  );
endinterface

// File: rtl/spi_byte_engine.sv
// spi_byte_engine
//   Byte-level SPI master. Accepts one byte per tx_dv/tx_ready handshake,
//   shifts it out MSB-first on spi_mosi while capturing 8 bits from
//   spi_miso, and returns the captured byte with a one-cycle rx_dv pulse.
//   Chip select is handled elsewhere.
// Parameters
//   SPI_MODE          : 0..3, CPOL = bit 1, CPHA = bit 0
//   CLKS_PER_HALF_BIT : clk cycles per spi_clk half period, >= 2
// Ports
//   clk      : system clock, rising edge
//   resetn   : synchronous active-low reset
//   bus      : byte handshake (tx_byte/tx_dv/tx_ready/rx_dv/rx_byte)
//   spi_clk  : registered SPI clock, idles at CPOL
//   spi_miso : serial data from slave (synchronous to the engine)
//   spi_mosi : registered serial data to slave
module spi_byte_engine #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  spi_byte_engine_if.slave     bus,
  output logic                 spi_clk,
  input  logic                 spi_miso,
  output logic                 spi_mosi
);

  if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
    $error("spi_byte_engine: CLKS_PER_HALF_BIT must be >= 2");
  end
  if (SPI_MODE < 0 || SPI_MODE > 3) begin : g_bad_mode
    $error("spi_byte_engine: SPI_MODE must be 0..3");
  end

  localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
  localparam logic CPHA = 1'(SPI_MODE & 1);
  localparam int   HW   = (CLKS_PER_HALF_BIT < 2) ? 1 : $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] half_cnt_reg;
  logic [4:0]    edge_cnt_reg;
  logic [7:0]    tx_shift_reg;
  logic [7:0]    rx_shift_reg;
  logic [7:0]    rx_byte_reg;
  logic          rx_dv_reg;
  logic          spi_clk_reg;
  logic          spi_mosi_reg;

  logic          ready;
  logic          accept;
  logic          half_wrap;
  logic          leading;
  logic [4:0]    edge_num;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake decode. DONE accepts exactly like IDLE so a
  // held tx_dv gives back-to-back bytes with no idle cycle in between.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    accept     = 1'b0;
    half_wrap  = 1'b0;
    edge_num   = edge_cnt_reg + 5'd1;   // spi_clk edge about to be registered
    leading    = edge_num[0];           // odd edges lead, even edges trail
    case (state_reg)
      IDLE, DONE: begin
        ready = 1'b1;
        if (bus.tx_dv) begin
          accept     = 1'b1;
          state_next = XFER;
        end else begin
          state_next = IDLE;
        end
      end
      XFER: begin
        half_wrap = (half_cnt_reg == HALF_LAST);
        if (half_wrap && edge_num == 5'd16) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: counters, spi_clk, shift registers, result register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      half_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_byte_reg  <= '0;
      rx_dv_reg    <= 1'b0;
      spi_clk_reg  <= CPOL;
      spi_mosi_reg <= 1'b0;
    end else begin
      // Result is published one cycle after DONE, so rx_byte and rx_dv
      // change together on the same edge.
      rx_dv_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        rx_byte_reg <= rx_shift_reg;
      end

      if (accept) begin
        tx_shift_reg <= bus.tx_byte;
        half_cnt_reg <= '0;
        edge_cnt_reg <= '0;
        // CPHA=0 needs bit 7 on the wire before the first leading edge
        if (!CPHA) begin
          spi_mosi_reg <= bus.tx_byte[7];
        end
      end else if (state_reg == XFER) begin
        if (half_wrap) begin
          half_cnt_reg <= '0;
          edge_cnt_reg <= edge_num;
          spi_clk_reg  <= ~spi_clk_reg;
          if (leading) begin
            if (CPHA) begin
              spi_mosi_reg <= tx_shift_reg[7];
              tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end else begin
              rx_shift_reg <= {rx_shift_reg[6:0], spi_miso};
            end
          end else begin
            if (CPHA) begin
              rx_shift_reg <= {rx_shift_reg[6:0], spi_miso};
            end else if (edge_num != 5'd16) begin
              // bit 7 already went out at accept; trailing edges carry 6..0
              spi_mosi_reg <= tx_shift_reg[6];
              tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
            end
          end
        end else begin
          half_cnt_reg <= half_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.tx_ready = ready;
  assign bus.rx_dv    = rx_dv_reg;
  assign bus.rx_byte  = rx_byte_reg;
  assign spi_clk      = spi_clk_reg;
  assign spi_mosi     = spi_mosi_reg;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine
//   Directed bench for spi_byte_engine: one mode-0 engine (N=2) and one
//   mode-3 engine (N=4) share clk/resetn. Each transfer is recorded
//   cycle by cycle relative to its accept edge T0, then the trace is
//   compared with hand-computed values.
module tb_spi_byte_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  spi_byte_engine_if bus0 ();
  spi_byte_engine_if bus3 ();

  logic spi_clk0, spi_mosi0, spi_miso0;
  logic spi_clk3, spi_mosi3, spi_miso3;

  spi_byte_engine #(.SPI_MODE(0), .CLKS_PER_HALF_BIT(2)) dut0 (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus0.slave),
    .spi_clk  (spi_clk0),
    .spi_miso (spi_miso0),
    .spi_mosi (spi_mosi0)
  );

  spi_byte_engine #(.SPI_MODE(3), .CLKS_PER_HALF_BIT(4)) dut3 (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus3.slave),
    .spi_clk  (spi_clk3),
    .spi_miso (spi_miso3),
    .spi_mosi (spi_mosi3)
  );

  // Slave models: counters of spi_clk falls, a sliding receive window on
  // rising edges, and a response byte indexed by falls since load.
  logic       loop0;
  logic [7:0] resp0, resp3;
  int         base0, base3;
  int         fall_cnt0 = 0;
  int         fall_cnt3 = 0;
  logic [7:0] srx0, srx3;
  logic       miso_s0, miso_s3;
  int         n0, n3;
  logic [7:0] sh0, sh3;

  always @(negedge spi_clk0) fall_cnt0 <= fall_cnt0 + 1;
  always @(negedge spi_clk3) fall_cnt3 <= fall_cnt3 + 1;
  always @(posedge spi_clk0) srx0 <= {srx0[6:0], spi_mosi0};
  always @(posedge spi_clk3) srx3 <= {srx3[6:0], spi_mosi3};

  // Mode 0: bit 7 before the first fall, next bit after each fall.
  // Mode 3: bit 7 after the first fall, next bit after each later fall.
  always @* begin
    n0 = fall_cnt0 - base0;
    sh0 = resp0 << n0;
    miso_s0 = sh0[7];
    n3 = fall_cnt3 - base3 - 1;
    if (n3 < 0) n3 = 0;
    sh3 = resp3 << n3;
    miso_s3 = sh3[7];
  end

  assign spi_miso0 = loop0 ? spi_mosi0 : miso_s0;
  assign spi_miso3 = miso_s3;

  // Per-cycle trace; index k = value just after edge T0+k
  logic       c0 [0:80];
  logic       m0 [0:80];
  logic       d0 [0:80];
  logic       r0 [0:80];
  logic [7:0] b0 [0:80];
  logic       c3 [0:80];
  logic       m3 [0:80];
  logic       d3 [0:80];
  logic       r3 [0:80];
  logic [7:0] b3 [0:80];

  int vectors = 0;
  int miscompares = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input bit which3, input logic [7:0] b);
    @(negedge clk);
    if (which3) begin
      bus3.tx_byte = b;
      bus3.tx_dv   = 1'b1;
    end else begin
      bus0.tx_byte = b;
      bus0.tx_dv   = 1'b1;
    end
  endtask

  // First edge recorded is T0. tx_dv drops after T0 unless hold is set;
  // inj_k/inj_byte raise bus0.tx_dv again, rel_k drops it.
  task automatic record(input int n, input bit hold, input int inj_k,
                        input logic [7:0] inj_byte, input int rel_k);
    for (int k = 0; k <= n; k++) begin
      @(posedge clk);
      #1;
      c0[k] = spi_clk0; m0[k] = spi_mosi0; d0[k] = bus0.rx_dv;
      r0[k] = bus0.tx_ready; b0[k] = bus0.rx_byte;
      c3[k] = spi_clk3; m3[k] = spi_mosi3; d3[k] = bus3.rx_dv;
      r3[k] = bus3.tx_ready; b3[k] = bus3.rx_byte;
      if (k == 0 && !hold) begin
        bus0.tx_dv = 1'b0;
        bus3.tx_dv = 1'b0;
      end
      if (k == inj_k) begin
        bus0.tx_dv   = 1'b1;
        bus0.tx_byte = inj_byte;
      end
      if (k == rel_k) begin
        bus0.tx_dv = 1'b0;
        bus3.tx_dv = 1'b0;
      end
    end
  endtask

  initial begin
    int rises, pulses, toggles, busy0, bad, p1, p2, r_first, r_second, r_ninth;
    logic [7:0] wire_byte;

    resetn = 1'b0;
    bus0.tx_dv = 1'b0; bus0.tx_byte = 8'h00;
    bus3.tx_dv = 1'b0; bus3.tx_byte = 8'h00;
    loop0 = 1'b1; resp0 = 8'h00; resp3 = 8'h00; base0 = 0; base3 = 0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst tx_ready0", bus0.tx_ready, 1'b1);
    check1("rst rx_dv0", bus0.rx_dv, 1'b0);
    check8("rst rx_byte0", bus0.rx_byte, 8'h00);
    check1("rst spi_clk0", spi_clk0, 1'b0);
    check1("rst mosi0", spi_mosi0, 1'b0);
    check1("rst spi_clk3", spi_clk3, 1'b1);
    check1("rst tx_ready3", bus3.tx_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    // ---- Mode 0 loopback, 0xA5 ----
    start(1'b0, 8'hA5);
    record(40, 1'b0, -1, 8'h00, -1);
    rises = 0; pulses = 0; busy0 = 0; bad = 0; wire_byte = 8'h00;
    r_first = -1; r_second = -1;
    for (int k = 1; k <= 40; k++) begin
      if (c0[k] && !c0[k-1]) begin
        rises++;
        wire_byte = {wire_byte[6:0], m0[k]};
        if (r_first < 0) r_first = k;
        else if (r_second < 0) r_second = k;
      end
      if (d0[k] && !d0[k-1]) pulses++;
      if (k <= 31 && !r0[k]) busy0++;
      if (m0[k] !== m0[k-1] && !(c0[k-1] && !c0[k])) bad++;
    end
    $display("xfer mode0 loopback tx=a5 rx=%h", b0[33]);
    check1("a5 tx_ready at T0+1", r0[0], 1'b0);
    checki("a5 first rise", r_first, 2);
    checki("a5 second rise", r_second, 6);
    checki("a5 rising edges", rises, 8);
    check8("a5 mosi sequence", wire_byte, 8'hA5);
    checki("a5 mosi only on falls", bad, 0);
    check1("a5 spi_clk idle at T0+32", c0[32], 1'b0);
    checki("a5 tx_ready low T0+1..31", busy0, 31);
    check1("a5 rx_dv T0+32", d0[32], 1'b0);
    check1("a5 rx_dv T0+33", d0[33], 1'b1);
    check1("a5 rx_dv T0+34", d0[34], 1'b0);
    check8("a5 rx_byte", b0[33], 8'hA5);
    checki("a5 rx_dv pulses", pulses, 1);

    // ---- Mode 0 slave model: send 0xC3, slave returns 0x3C ----
    @(negedge clk);
    loop0 = 1'b0; resp0 = 8'h3C; base0 = fall_cnt0;
    start(1'b0, 8'hC3);
    record(40, 1'b0, -1, 8'h00, -1);
    $display("xfer mode0 slave tx=c3 rx=%h slave_rx=%h", b0[33], srx0);
    check1("c3 rx_dv T0+33", d0[33], 1'b1);
    check8("c3 rx_byte", b0[33], 8'h3C);
    check8("c3 slave received", srx0, 8'hC3);

    // ---- Busy rejection: 0x11, then 0xFF pulsed at T0+10 ----
    @(negedge clk);
    loop0 = 1'b1;
    start(1'b0, 8'h11);
    record(40, 1'b0, 9, 8'hFF, 10);
    pulses = 0; busy0 = 0; wire_byte = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      if (c0[k] && !c0[k-1]) wire_byte = {wire_byte[6:0], m0[k]};
      if (d0[k] && !d0[k-1]) pulses++;
      if (k <= 31 && !r0[k]) busy0++;
    end
    $display("xfer mode0 busy tx=11 rx=%h", b0[33]);
    check8("busy wire byte", wire_byte, 8'h11);
    checki("busy rx_dv pulses", pulses, 1);
    check8("busy rx_byte", b0[33], 8'h11);
    checki("busy tx_ready low T0+1..31", busy0, 31);
    check1("busy tx_ready T0+33", r0[33], 1'b1);

    // ---- Back-to-back: tx_dv held, 0x01 then 0x80 ----
    start(1'b0, 8'h01);
    record(70, 1'b1, 0, 8'h80, 33);
    pulses = 0; toggles = 0; rises = 0; p1 = -1; p2 = -1; r_ninth = -1;
    for (int k = 1; k <= 70; k++) begin
      if (c0[k] !== c0[k-1]) toggles++;
      if (c0[k] && !c0[k-1]) begin
        rises++;
        if (rises == 9) r_ninth = k;
      end
      if (d0[k] && !d0[k-1]) begin
        pulses++;
        if (p1 < 0) p1 = k; else p2 = k;
      end
    end
    $display("xfer mode0 b2b tx=01,80 rx=%h,%h", b0[33], b0[66]);
    check1("b2b second accept T0+33", r0[33], 1'b0);
    checki("b2b first of second byte rise", r_ninth, 35);
    checki("b2b spi_clk toggles", toggles, 32);
    checki("b2b rx_dv pulses", pulses, 2);
    checki("b2b pulse spacing", p2 - p1, 33);
    check8("b2b rx_byte 1", b0[33], 8'h01);
    check8("b2b rx_byte 2", b0[66], 8'h80);

    // ---- Reset mid-transfer at T0+12, then 0x5A ----
    start(1'b0, 8'h77);
    record(11, 1'b0, -1, 8'h00, -1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    $display("xfer mode0 aborted tx=77");
    check1("rst-mid spi_clk", spi_clk0, 1'b0);
    check1("rst-mid tx_ready", bus0.tx_ready, 1'b1);
    check8("rst-mid rx_byte", bus0.rx_byte, 8'h00);
    check1("rst-mid rx_dv", bus0.rx_dv, 1'b0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus0.rx_dv) pulses++;
    end
    checki("rst-mid no rx_dv", pulses, 0);
    start(1'b0, 8'h5A);
    record(40, 1'b0, -1, 8'h00, -1);
    $display("xfer mode0 after reset tx=5a rx=%h", b0[33]);
    check1("5a rx_dv T0+33", d0[33], 1'b1);
    check8("5a rx_byte", b0[33], 8'h5A);

    // ---- Mode 3, N=4: send 0x69, slave returns 0x96 ----
    @(negedge clk);
    resp3 = 8'h96; base3 = fall_cnt3;
    start(1'b1, 8'h69);
    record(70, 1'b0, -1, 8'h00, -1);
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      if (m3[k] !== m3[k-1] && !(c3[k-1] && !c3[k])) bad++;
    end
    $display("xfer mode3 tx=69 rx=%h slave_rx=%h", b3[65], srx3);
    check1("m3 tx_ready at T0+1", r3[0], 1'b0);
    check1("m3 spi_clk idle T0", c3[0], 1'b1);
    check1("m3 spi_clk T0+3", c3[3], 1'b1);
    check1("m3 first fall T0+4", c3[4], 1'b0);
    checki("m3 mosi only on falls", bad, 0);
    check1("m3 spi_clk idle T0+64", c3[64], 1'b1);
    check1("m3 rx_dv T0+64", d3[64], 1'b0);
    check1("m3 rx_dv T0+65", d3[65], 1'b1);
    check1("m3 rx_dv T0+66", d3[66], 1'b0);
    check8("m3 rx_byte", b3[65], 8'h96);
    check8("m3 slave received", srx3, 8'h69);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
